// File: rtl/myproject_mul_share_sched.sv
// myproject_mul_share_sched
//
// Shares one signed A_W x unsigned B_W multiplier among NUM_REQ requesters.
// A round-robin arbiter grants one requester per cycle. The operand pair
// passes through two registered stages, S1 (operands) and S2 (product), and
// leaves on one result stream tagged with the requester index.
//
// Ports
//   ap_clk     : clock, rising edge
//   ap_rst_n   : asynchronous active-low reset
//   req_valid  : per-requester operand valid          [NUM_REQ]
//   req_ready  : per-requester accept, one-hot or 0   [NUM_REQ]
//   req_a      : packed signed operands, i at [i*A_W +: A_W]
//   req_b      : packed unsigned operands, i at [i*B_W +: B_W]
//   res_valid  : result valid
//   res_ready  : downstream accept
//   res_data   : signed product                       [P_W]
//   res_id     : index of the requester that produced res_data
//   busy       : any pipeline stage holds data
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds its payload stable while valid & !ready. req_ready
// depends only on req_valid, res_ready and internal state, never on the
// operands. res_data/res_id stay stable while res_valid & !res_ready.
module myproject_mul_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 14,
  parameter int B_W     = 13,
  parameter int P_W     = 27
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [P_W-1:0]         res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  // Stage S1: captured operands
  logic            s1_valid;
  logic [A_W-1:0]  s1_a;
  logic [B_W-1:0]  s1_b;
  logic [ID_W-1:0] s1_id;

  // Stage S2: product waiting for the consumer
  logic            s2_valid;
  logic [P_W-1:0]  s2_data;
  logic [ID_W-1:0] s2_id;

  // Round-robin pointer: the most recently granted requester
  logic [ID_W-1:0] last;

  logic            adv1;
  logic            adv2;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] grant_id;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod;

  assign adv2 = !s2_valid || res_ready;
  assign adv1 = !s1_valid || adv2;

  // Round-robin search. Requesters above `last` take priority over those at
  // or below it, and within each group the lowest index wins. Together these
  // give a search from last+1 that wraps around. Both loops run downwards, so
  // the last hit they record is the lowest index in the group.
  always_comb begin
    logic            found_hi;
    logic            found_lo;
    logic [ID_W-1:0] g_hi;
    logic [ID_W-1:0] g_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    g_hi     = '0;
    g_lo     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(last))) begin
        found_hi = 1'b1;
        g_hi     = ID_W'(i);
      end
      if (req_valid[i] && (i <= int'(last))) begin
        found_lo = 1'b1;
        g_lo     = ID_W'(i);
      end
    end
    found    = found_hi || found_lo;
    grant_id = found_hi ? g_hi : g_lo;
  end

  // The reset term keeps every req_ready low while the block is held in reset.
  assign accept = ap_rst_n && found && adv1;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[i*A_W +: A_W];
        sel_b        = req_b[i*B_W +: B_W];
      end
    end
  end

  // a is sign-extended and b is zero-extended to the full product width.
  // The low P_W bits of the product are then the exact signed result.
  assign a_ext = {{(P_W - A_W){s1_a[A_W-1]}}, s1_a};
  assign b_ext = {{(P_W - B_W){1'b0}}, s1_b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
      last     <= ID_W'(NUM_REQ - 1);
    end else begin
      if (adv1) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= grant_id;
          last  <= grant_id;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= prod;
          s2_id   <= s1_id;
        end
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_data  = s2_data;
  assign res_id    = s2_id;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_myproject_mul_share_sched.sv
module tb_myproject_mul_share_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 14;
  localparam int B_W     = 13;
  localparam int P_W     = 27;

  logic                   ap_clk;
  logic                   ap_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic signed [P_W-1:0]  res_data;
  logic [ID_W-1:0]        res_id;
  logic                   busy;

  int n_checks;
  int n_errors;

  // Expected results in issue order, packed as {id, product}
  logic [P_W+ID_W-1:0] exp_q[$];
  int                  grant_log[$];

  myproject_mul_share_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge ap_clk);
  endtask

  task automatic set_req(input int i, input logic signed [A_W-1:0] a,
                         input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 10 && busy; i++) tick();
    #1;
    check("drain_busy", busy, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // This samples 2 time units after each falling edge. It records what the
  // next rising edge will transfer: each accept pushes the modelled product,
  // and each result pop is compared with the head of the queue.
  always begin
    @(negedge ap_clk);
    #2;
    if (ap_rst_n) begin
      check("ready_onehot", ($countones(req_ready) <= 1), 1);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_result", exp_q.size(), 1);
        end else begin
          logic [P_W+ID_W-1:0] e;
          e = exp_q.pop_front();
          check("sb_data", res_data, $signed(e[P_W-1:0]));
          check("sb_id", res_id, e[P_W+ID_W-1:P_W]);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          longint pa;
          longint pb;
          longint p;
          pa = longint'($signed(req_a[i*A_W +: A_W]));
          pb = longint'(req_b[i*B_W +: B_W]);
          p  = pa * pb;
          exp_q.push_back({ID_W'(i), P_W'(p)});
          grant_log.push_back(i);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    n_checks  = 0;
    n_errors  = 0;
    ap_rst_n  = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    // Reset state: everything is quiet even though all requesters are valid
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    tick();
    tick();
    ap_rst_n  = 1'b1;
    req_valid = '0;

    // Single ops at the extremes of the operand range, with latency checks
    tick();
    set_req(0, -14'sd8192, 13'd8191);
    req_valid = 4'b0001;
    #1;
    check("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    check("lat_not_yet", res_valid, 0);
    check("lat_busy", busy, 1);
    tick();
    set_req(0, 14'sd8191, 13'd8191);
    req_valid = 4'b0001;
    #1;
    check("min_valid", res_valid, 1);
    check("min_data", res_data, -67100672);
    check("min_id", res_id, 0);
    tick();
    req_valid = '0;
    #1;
    check("gap_valid", res_valid, 0);
    tick();
    #1;
    check("max_valid", res_valid, 1);
    check("max_data", res_data, 67092481);
    tick();
    drain();

    // Round-robin with all four requesters, starting from a fresh pointer.
    // Requester i supplies a=i+1 and b=10*(i+1).
    tick();
    ap_rst_n = 1'b0;
    exp_q.delete();
    tick();
    ap_rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, A_W'(i + 1), B_W'(10 * (i + 1)));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", req_ready, 1 << (k % 4));
      if (k >= 2) begin
        check("rr_res_id", res_id, (k - 2) % 4);
        check("rr_res_data", res_data, 10 * ((k - 2) % 4 + 1) * ((k - 2) % 4 + 1));
      end
      tick();
    end
    drain();

    // Skip and wrap: the pointer sits at 3 after the round-robin run
    tick();
    req_valid = 4'b0100;
    #1;
    check("skip_g2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1010;
    #1;
    check("skip_g3", req_ready, 4'b1000);
    tick();
    #1;
    check("skip_g1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1001;
    #1;
    check("wrap_g3", req_ready, 4'b1000);
    tick();
    #1;
    check("wrap_g0", req_ready, 4'b0001);
    tick();
    drain();

    // Backpressure from a stream on requester 1
    tick();
    res_ready = 1'b0;
    req_valid = 4'b0010;
    set_req(1, -14'sd3, 13'd7);
    n0 = grant_log.size();
    #1;
    check("bp_ready0", req_ready, 4'b0010);
    tick();
    set_req(1, 14'sd1000, 13'd4000);
    #1;
    check("bp_ready1", req_ready, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      set_req(1, A_W'(5 + k), 13'd9);
      #1;
      check("bp_full_ready", req_ready, 0);
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, -21);
      check("bp_hold_id", res_id, 1);
    end
    check("bp_accepts", grant_log.size() - n0, 2);
    tick();
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    check("bp_rel_data0", res_data, -21);
    tick();
    #1;
    check("bp_rel_valid1", res_valid, 1);
    check("bp_rel_data1", res_data, 4000000);
    check("bp_rel_id1", res_id, 1);
    tick();
    #1;
    check("bp_rel_empty", res_valid, 0);
    drain();

    // Reset in the middle of an operation with both stages full
    tick();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("mid_ready", (req_ready != 0), 1);
    tick();
    tick();
    #1;
    check("mid_full_busy", busy, 1);
    ap_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    tick();
    ap_rst_n  = 1'b1;
    res_ready = 1'b1;
    #1;
    check("mid_first_grant", req_ready, 4'b0001);
    tick();
    drain();

    // Random mix of valids, operands and backpressure against the scoreboard
    for (int k = 0; k < 300; k++) begin
      tick();
      req_valid = NUM_REQ'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, A_W'($urandom_range(0, 16383)), B_W'($urandom_range(0, 8191)));
      res_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    drain();
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
